// File: rtl/board_scorer.sv
// board_scorer: walks the 64-cell Othello board after each move, counts black,
// white and empty cells, converts the scores to BCD and decides game over and winner.
module board_scorer #(
    parameter int READ_LATENCY = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       pass,
    input  logic       placed,
    output logic [2:0] rd_x,
    output logic [2:0] rd_y,
    output logic       rd_en,
    input  logic [1:0] q,
    output logic       busy,
    output logic       done,
    output logic [6:0] black_count,
    output logic [6:0] white_count,
    output logic [7:0] black_bcd,
    output logic [7:0] white_bcd,
    output logic       win,
    output logic [1:0] winner,
    output logic [1:0] o_dbg_state
);

    // Handshake: start is a one-cycle request accepted only while busy is low; each
    // accepted start yields exactly one done pulse (unless reset intervenes), and the
    // result outputs are valid from that done cycle until the next done.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_FINAL = 2'd3
    } state_t;

    localparam logic DRAIN_LAST = 1'(READ_LATENCY - 1);

    state_t                  r_state;
    logic [5:0]              r_addr;
    logic                    r_rd_en;
    logic                    r_drain;
    logic                    r_done;
    logic [READ_LATENCY-1:0] r_vld;
    logic [6:0]              r_black;
    logic [6:0]              r_white;
    logic [6:0]              r_empty;
    logic [1:0]              r_pass_cnt;
    logic [6:0]              r_black_count;
    logic [6:0]              r_white_count;
    logic [7:0]              r_black_bcd;
    logic [7:0]              r_white_bcd;
    logic                    r_win;
    logic [1:0]              r_winner;

    logic [READ_LATENCY:0]   w_vld_shift;
    logic                    w_vld_out;
    logic                    w_clear;
    logic [7:0]              w_black_bcd;
    logic [7:0]              w_white_bcd;
    logic                    w_win;
    logic [1:0]              w_winner;

    // Counts never exceed 64, so a compare chain for the tens digit is enough.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        if (v >= 7'd60)      tens = 4'd6;
        else if (v >= 7'd50) tens = 4'd5;
        else if (v >= 7'd40) tens = 4'd4;
        else if (v >= 7'd30) tens = 4'd3;
        else if (v >= 7'd20) tens = 4'd2;
        else if (v >= 7'd10) tens = 4'd1;
        else                 tens = 4'd0;
        ones = 4'(v - 7'(tens) * 7'd10);
        return {tens, ones};
    endfunction

    assign w_clear     = (r_state == S_IDLE) && start;
    assign w_vld_shift = {r_vld, r_rd_en};
    assign w_vld_out   = w_vld_shift[READ_LATENCY];
    assign w_black_bcd = to_bcd(r_black);
    assign w_white_bcd = to_bcd(r_white);
    assign w_win       = (r_empty == 7'd0) || (r_black == 7'd0) ||
                         (r_white == 7'd0) || (r_pass_cnt == 2'd2);

    always_comb begin
        w_winner = 2'b00;
        if (w_win) begin
            if (r_black > r_white)      w_winner = 2'b01;
            else if (r_white > r_black) w_winner = 2'b10;
            else                        w_winner = 2'b11;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            r_state       <= S_IDLE;
            r_addr        <= 6'd0;
            r_rd_en       <= 1'b0;
            r_drain       <= 1'b0;
            r_done        <= 1'b0;
            r_black_count <= 7'd0;
            r_white_count <= 7'd0;
            r_black_bcd   <= 8'd0;
            r_white_bcd   <= 8'd0;
            r_win         <= 1'b0;
            r_winner      <= 2'b00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SCAN;
                        r_addr  <= 6'd0;
                        r_rd_en <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (r_addr == 6'd63) begin
                        r_state <= S_DRAIN;
                        r_rd_en <= 1'b0;
                        r_drain <= 1'b0;
                    end else begin
                        r_addr <= r_addr + 6'd1;
                    end
                end
                S_DRAIN: begin
                    // The last read returns while we wait here; it lands on the exit edge.
                    if (r_drain == DRAIN_LAST) r_state <= S_FINAL;
                    else                       r_drain <= r_drain + 1'b1;
                end
                S_FINAL: begin
                    r_black_count <= r_black;
                    r_white_count <= r_white;
                    r_black_bcd   <= w_black_bcd;
                    r_white_bcd   <= w_white_bcd;
                    r_win         <= w_win;
                    r_winner      <= w_winner;
                    r_done        <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) r_vld <= '0;
        else        r_vld <= w_vld_shift[READ_LATENCY-1:0];
    end

    always_ff @(posedge clock) begin
        if (resetn || w_clear) begin
            r_black <= 7'd0;
            r_white <= 7'd0;
            r_empty <= 7'd0;
        end else if (w_vld_out) begin
            case (q)
                2'b01:   r_black <= r_black + 7'd1;
                2'b10:   r_white <= r_white + 7'd1;
                default: r_empty <= r_empty + 7'd1;
            endcase
        end
    end

    // A placement in the same cycle as a pass means play continued, so clear wins.
    always_ff @(posedge clock) begin
        if (resetn || placed)                r_pass_cnt <= 2'd0;
        else if (pass && r_pass_cnt != 2'd2) r_pass_cnt <= r_pass_cnt + 2'd1;
    end

    assign rd_x        = r_addr[2:0];
    assign rd_y        = r_addr[5:3];
    assign rd_en       = r_rd_en;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign black_count = r_black_count;
    assign white_count = r_white_count;
    assign black_bcd   = r_black_bcd;
    assign white_bcd   = r_white_bcd;
    assign win         = r_win;
    assign winner      = r_winner;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_board_scorer.sv
// Bench for board_scorer: runs a READ_LATENCY=1 and a READ_LATENCY=2 instance side by
// side on the same board image and compares both against a counting model of the rules.
module tb_board_scorer;

    localparam int W = 33;

    logic       clock = 1'b0;
    logic       resetn, start1, start2, pass, placed;
    logic [2:0] rd_x1, rd_y1, rd_x2, rd_y2;
    logic       rd_en1, rd_en2, busy1, busy2, done1, done2, win1, win2;
    logic [1:0] q1, q2, winner1, winner2, dbg1, dbg2;
    logic [6:0] bc1, wc1, bc2, wc2;
    logic [7:0] bb1, wb1, bb2, wb2;

    logic [1:0] board [64];
    logic [1:0] m1, m2a, m2b;

    int total = 0;
    int bad   = 0;
    int m_pass = 0;
    logic [W-1:0] exp_q[$];

    int s_d1, s_d2, s_nd1, s_nd2, s_ld1, s_ld2, s_seq1, s_seq2, s_hold, s_zero;
    logic [W-1:0] s_res1, s_res2;

    always #10 clock = ~clock;

    board_scorer #(.READ_LATENCY(1)) dut_l1 (
        .clock(clock), .resetn(resetn), .start(start1), .pass(pass), .placed(placed),
        .rd_x(rd_x1), .rd_y(rd_y1), .rd_en(rd_en1), .q(q1), .busy(busy1), .done(done1),
        .black_count(bc1), .white_count(wc1), .black_bcd(bb1), .white_bcd(wb1),
        .win(win1), .winner(winner1), .o_dbg_state(dbg1)
    );

    board_scorer #(.READ_LATENCY(2)) dut_l2 (
        .clock(clock), .resetn(resetn), .start(start2), .pass(pass), .placed(placed),
        .rd_x(rd_x2), .rd_y(rd_y2), .rd_en(rd_en2), .q(q2), .busy(busy2), .done(done2),
        .black_count(bc2), .white_count(wc2), .black_bcd(bb2), .white_bcd(wb2),
        .win(win2), .winner(winner2), .o_dbg_state(dbg2)
    );

    // Board memory read ports with one and two cycles of latency.
    always @(posedge clock) begin
        m1  <= board[{rd_y1, rd_x1}];
        m2a <= board[{rd_y2, rd_x2}];
        m2b <= m2a;
    end
    assign q1 = m1;
    assign q2 = m2b;

    function automatic logic [W-1:0] pack1();
        return {bc1, wc1, bb1, wb1, win1, winner1};
    endfunction

    function automatic logic [W-1:0] pack2();
        return {bc2, wc2, bb2, wb2, win2, winner2};
    endfunction

    function automatic logic [W-1:0] model_result();
        int b = 0;
        int w = 0;
        int e;
        bit over;
        logic [1:0] wn;
        for (int i = 0; i < 64; i++) begin
            if (board[i] == 2'b01)      b++;
            else if (board[i] == 2'b10) w++;
        end
        e = 64 - b - w;
        over = (e == 0) || (b == 0) || (w == 0) || (m_pass == 2);
        if (!over)      wn = 2'b00;
        else if (b > w) wn = 2'b01;
        else if (w > b) wn = 2'b10;
        else            wn = 2'b11;
        return {7'(b), 7'(w), 4'(b / 10), 4'(b % 10), 4'(w / 10), 4'(w % 10), over, wn};
    endfunction

    // emode: 0 empties are 00, 1 empties are 11, 2 empties mixed 00/11
    task automatic fill_board(input int nb, input int nw, input int emode);
        int idx[64];
        int j, t;
        for (int i = 0; i < 64; i++) idx[i] = i;
        for (int i = 63; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = idx[i]; idx[i] = idx[j]; idx[j] = t;
        end
        for (int i = 0; i < 64; i++) begin
            if (i < nb)           board[idx[i]] = 2'b01;
            else if (i < nb + nw) board[idx[i]] = 2'b10;
            else if (emode == 1 || (emode == 2 && $urandom_range(1, 0) == 1))
                board[idx[i]] = 2'b11;
            else
                board[idx[i]] = 2'b00;
        end
    endtask

    task automatic pulse(input logic p, input logic pl);
        @(negedge clock);
        pass = p;
        placed = pl;
        @(posedge clock);
        #1;
        pass = 1'b0;
        placed = 1'b0;
        if (pl)                    m_pass = 0;
        else if (p && m_pass < 2)  m_pass++;
    endtask

    // Starts both instances at edge E0 and observes them for max_n further edges.
    // xs_n: edge of an extra start; rst_n: edge of a reset; b2b: restart on done.
    task automatic do_scan(input int max_n, input int xs_n, input int rst_n, input bit b2b,
                           input bit hold, input logic [W-1:0] hold_exp);
        s_d1 = -1; s_d2 = -1; s_nd1 = 0; s_nd2 = 0; s_ld1 = -1; s_ld2 = -1;
        s_seq1 = 0; s_seq2 = 0; s_hold = 0; s_zero = 0; s_res1 = '0; s_res2 = '0;
        @(negedge clock);
        start1 = 1'b1;
        start2 = 1'b1;
        @(posedge clock);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        for (int n = 0; n <= max_n; n++) begin
            if (n > 0) begin
                @(posedge clock);
                #1;
                start1 = 1'b0;
                start2 = 1'b0;
                resetn = 1'b0;
            end
            @(negedge clock);
            if (rst_n >= 0 && n == rst_n) begin
                if ({pack1(), busy1, done1, rd_en1, rd_x1, rd_y1} !== '0) s_zero++;
                if ({pack2(), busy2, done2, rd_en2, rd_x2, rd_y2} !== '0) s_zero++;
            end
            if (rst_n < 0 || n < rst_n) begin
                if (!b2b || n <= 66) begin
                    if (busy1 !== (n <= 65)) s_seq1++;
                    if (rd_en1 !== (n <= 63)) s_seq1++;
                    if (n <= 63 && {rd_y1, rd_x1} !== 6'(n)) s_seq1++;
                end
                if (!b2b || n <= 67) begin
                    if (busy2 !== (n <= 66)) s_seq2++;
                    if (rd_en2 !== (n <= 63)) s_seq2++;
                    if (n <= 63 && {rd_y2, rd_x2} !== 6'(n)) s_seq2++;
                end
                if (hold && n <= 65 && pack1() !== hold_exp) s_hold++;
                if (hold && n <= 66 && pack2() !== hold_exp) s_hold++;
            end
            if (done1 === 1'b1) begin
                s_nd1++;
                if (s_nd1 == 1) s_d1 = n;
                s_ld1 = n;
                s_res1 = pack1();
                if (b2b && s_nd1 == 1) start1 = 1'b1;
            end
            if (done2 === 1'b1) begin
                s_nd2++;
                if (s_nd2 == 1) s_d2 = n;
                s_ld2 = n;
                s_res2 = pack2();
                if (b2b && s_nd2 == 1) start2 = 1'b1;
            end
            if (n + 1 == xs_n) begin
                start1 = 1'b1;
                start2 = 1'b1;
            end
            if (n + 1 == rst_n) resetn = 1'b1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++;
        if ({pack1(), busy1, done1, rd_en1, rd_x1, rd_y1} !== '0) begin
            bad++; $display("FAIL reset_l1: got %h want 0", {pack1(), busy1, done1, rd_en1, rd_x1, rd_y1});
        end
        total++;
        if ({pack2(), busy2, done2, rd_en2, rd_x2, rd_y2} !== '0) begin
            bad++; $display("FAIL reset_l2: got %h want 0", {pack2(), busy2, done2, rd_en2, rd_x2, rd_y2});
        end
        resetn = 1'b0;
        m_pass = 0;
    endtask

    task automatic test_start_board();
        logic [W-1:0] exp;
        for (int i = 0; i < 64; i++) board[i] = 2'b00;
        board[27] = 2'b10; board[36] = 2'b10; board[28] = 2'b01; board[35] = 2'b01;
        exp = model_result();
        do_scan(75, -1, -1, 1'b0, 1'b0, '0);
        total++; if (s_d1 != 66) begin bad++; $display("FAIL start_done_edge_l1: got %0d want 66", s_d1); end
        total++; if (s_d2 != 67) begin bad++; $display("FAIL start_done_edge_l2: got %0d want 67", s_d2); end
        total++; if (s_nd1 != 1) begin bad++; $display("FAIL start_done_cycles_l1: got %0d want 1", s_nd1); end
        total++; if (s_nd2 != 1) begin bad++; $display("FAIL start_done_cycles_l2: got %0d want 1", s_nd2); end
        total++; if (s_seq1 != 0) begin bad++; $display("FAIL start_addr_busy_l1: got %0d errors want 0", s_seq1); end
        total++; if (s_seq2 != 0) begin bad++; $display("FAIL start_addr_busy_l2: got %0d errors want 0", s_seq2); end
        total++; if (s_res1 !== exp) begin bad++; $display("FAIL start_result_l1: got %h want %h", s_res1, exp); end
        total++; if (s_res2 !== exp) begin bad++; $display("FAIL start_result_l2: got %h want %h", s_res2, exp); end
    endtask

    task automatic test_board_case(input string name, input int nb, input int nw, input int emode);
        logic [W-1:0] exp;
        fill_board(nb, nw, emode);
        exp = model_result();
        do_scan(75, -1, -1, 1'b0, 1'b0, '0);
        total++; if (s_res1 !== exp) begin bad++; $display("FAIL %s_l1: got %h want %h", name, s_res1, exp); end
        total++; if (s_res2 !== exp) begin bad++; $display("FAIL %s_l2: got %h want %h", name, s_res2, exp); end
    endtask

    task automatic test_pass_count();
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        test_board_case("pass_twice", 10, 12, 0);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        test_board_case("pass_placed_pass", 10, 12, 0);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        test_board_case("pass_with_placed", 10, 12, 0);
        pulse(1'b0, 1'b1);
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] exp;
        fill_board(int'($urandom_range(30, 1)), int'($urandom_range(30, 1)), 2);
        exp = model_result();
        do_scan(90, 20, -1, 1'b0, 1'b0, '0);
        total++; if (s_nd1 != 1) begin bad++; $display("FAIL busy_start_dones_l1: got %0d want 1", s_nd1); end
        total++; if (s_nd2 != 1) begin bad++; $display("FAIL busy_start_dones_l2: got %0d want 1", s_nd2); end
        total++; if (s_seq1 != 0 || s_seq2 != 0) begin
            bad++; $display("FAIL busy_start_seq: got %0d/%0d errors want 0", s_seq1, s_seq2);
        end
        total++; if (s_res2 !== exp) begin bad++; $display("FAIL busy_start_result_l2: got %h want %h", s_res2, exp); end
    endtask

    task automatic test_reset_mid_scan();
        fill_board(int'($urandom_range(30, 1)), int'($urandom_range(30, 1)), 0);
        do_scan(75, -1, 30, 1'b0, 1'b0, '0);
        m_pass = 0;
        total++; if (s_zero != 0) begin bad++; $display("FAIL reset_mid_zero: got %0d nonzero want 0", s_zero); end
        total++; if (s_nd1 != 0 || s_nd2 != 0) begin
            bad++; $display("FAIL reset_mid_done: got %0d/%0d dones want 0", s_nd1, s_nd2);
        end
        test_board_case("after_reset", 17, 9, 2);
    endtask

    task automatic test_code11_hold();
        logic [W-1:0] prev;
        logic [W-1:0] exp;
        fill_board(20, 20, 1);
        prev = model_result();
        do_scan(75, -1, -1, 1'b0, 1'b0, '0);
        total++; if (s_res1 !== prev) begin bad++; $display("FAIL code11_l1: got %h want %h", s_res1, prev); end
        total++; if (s_res2 !== prev) begin bad++; $display("FAIL code11_l2: got %h want %h", s_res2, prev); end
        fill_board(30, 25, 2);
        exp = model_result();
        do_scan(75, -1, -1, 1'b0, 1'b1, prev);
        total++; if (s_hold != 0) begin bad++; $display("FAIL hold: got %0d changes want 0", s_hold); end
        total++; if (s_res1 !== exp) begin bad++; $display("FAIL hold_next_l1: got %h want %h", s_res1, exp); end
    endtask

    task automatic test_random();
        logic [W-1:0] exp;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 64; i++) board[i] = 2'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1) pulse(1'b1, 1'b0);
            exp_q.push_back(model_result());
            do_scan(70, -1, -1, 1'b0, 1'b0, '0);
            exp = exp_q.pop_front();
            total++; if (s_res1 !== exp) begin bad++; $display("FAIL random%0d_l1: got %h want %h", k, s_res1, exp); end
            total++; if (s_res2 !== exp) begin bad++; $display("FAIL random%0d_l2: got %h want %h", k, s_res2, exp); end
        end
        pulse(1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp;
        fill_board(int'($urandom_range(40, 1)), int'($urandom_range(20, 1)), 2);
        exp_q.push_back(model_result());
        exp_q.push_back(model_result());
        do_scan(140, -1, -1, 1'b1, 1'b0, '0);
        total++; if (s_nd1 != 2 || s_ld1 != 133) begin
            bad++; $display("FAIL b2b_l1: got %0d dones last %0d want 2 last 133", s_nd1, s_ld1);
        end
        total++; if (s_nd2 != 2 || s_ld2 != 135) begin
            bad++; $display("FAIL b2b_l2: got %0d dones last %0d want 2 last 135", s_nd2, s_ld2);
        end
        void'(exp_q.pop_front());
        exp = exp_q.pop_front();
        total++; if (s_res1 !== exp) begin bad++; $display("FAIL b2b_result_l1: got %h want %h", s_res1, exp); end
        total++; if (s_res2 !== exp) begin bad++; $display("FAIL b2b_result_l2: got %h want %h", s_res2, exp); end
    endtask

    initial begin
        resetn = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        pass   = 1'b0;
        placed = 1'b0;
        for (int i = 0; i < 64; i++) board[i] = 2'b00;
        test_reset();
        test_start_board();
        test_board_case("full_40_24", 40, 24, 0);
        test_board_case("no_white", 5, 0, 2);
        test_board_case("draw_32_32", 32, 32, 0);
        test_pass_count();
        test_ignored_start();
        test_reset_mid_scan();
        test_code11_hold();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
